dist_filter: RTL and testbench

DIST_FILTER -- requirements
Module: dist_filter

---
 rtl/dist_filter.sv | 124 ++++++++++++
 tb/tb_dist_filter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dist_filter.sv
// dist_filter -- moving-average distance filter with hysteretic proximity flag.
//
// Keeps a circular window of the last DEPTH accepted 8-bit distance samples
// and a running sum. Once the window is full, every accepted sample produces
// a truncated average two cycles later. The near flag is re-evaluated on
// each new average against the near/far thresholds.
//
// Optional build macro: DIST_FILTER_REJECT_EN -- when defined, samples of 0
// (no echo) and 255 (out of range) are dropped without touching any state.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   dist_valid   strobe: dist_in carries a new measurement
//   dist_in      raw distance, cm, unsigned
//   thresh_near  near-assert threshold, cm
//   thresh_far   near-release threshold, cm
//   avg_out      filtered distance, cm (held between strobes)
//   avg_valid    strobe: avg_out just updated
//   near         hysteretic proximity flag
//   primed       window holds DEPTH accepted samples
module dist_filter #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dist_valid,
  input  logic [7:0] dist_in,
  input  logic [7:0] thresh_near,
  input  logic [7:0] thresh_far,
  output logic [7:0] avg_out,
  output logic       avg_valid,
  output logic       near,
  output logic       primed
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SUM_W = 8 + PTR_W;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [7:0]       win [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] fill_cnt;
  logic [SUM_W-1:0] sum_p0;
  logic             vld_p0;

  logic             accept;
  logic             last_fill;
  logic [SUM_W-1:0] sum_next;

  // Truncating average: DEPTH is a power of two, so a shift is exact.
  function automatic logic [7:0] avg_trunc(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] sh;
    sh = s >> PTR_W;
    return sh[7:0];
  endfunction

  // Hysteresis: the set test is checked first so it wins when the
  // thresholds are inverted.
  function automatic logic near_next(input logic [7:0] a,
                                     input logic [7:0] tn,
                                     input logic [7:0] tf,
                                     input logic       cur);
    if (a < tn)
      return 1'b1;
    else if (a > tf)
      return 1'b0;
    return cur;
  endfunction

  always_comb begin
    accept = dist_valid;
`ifdef DIST_FILTER_REJECT_EN
    if (dist_in == 8'd0 || dist_in == 8'd255)
      accept = 1'b0;
`endif
    last_fill = (state == FILL) && (fill_cnt == PTR_W'(DEPTH - 1));
    // Never negative: the slot being replaced is part of sum_p0.
    sum_next  = sum_p0 - SUM_W'(win[wr_ptr]) + SUM_W'(dist_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      for (int i = 0; i < DEPTH; i++)
        win[i] <= 8'd0;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      sum_p0    <= '0;
      vld_p0    <= 1'b0;
      avg_out   <= 8'd0;
      avg_valid <= 1'b0;
      near      <= 1'b0;
      primed    <= 1'b0;
    end else begin
      // p0: window write, running sum, pointer and fill tracking
      if (accept) begin
        win[wr_ptr] <= dist_in;
        sum_p0      <= sum_next;
        wr_ptr      <= wr_ptr + 1'b1;
        if (state == FILL) begin
          fill_cnt <= fill_cnt + 1'b1;
          if (last_fill) begin
            state  <= RUN;
            primed <= 1'b1;
          end
        end
      end
      // The sample that completes the fill already yields an average.
      vld_p0 <= accept && ((state == RUN) || last_fill);

      // p1: average and proximity evaluation on the freshly registered sum
      avg_valid <= vld_p0;
      if (vld_p0) begin
        avg_out <= avg_trunc(sum_p0);
        near    <= near_next(avg_trunc(sum_p0), thresh_near, thresh_far, near);
      end
    end
  end

endmodule

// File: tb/tb_dist_filter.sv
// tb_dist_filter -- self-checking bench for dist_filter (DEPTH = 4).
// A queue-based moving-average model predicts every avg_valid strobe,
// avg_out value, near flag and primed flag cycle by cycle.
module tb_dist_filter;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dist_valid = 1'b0;
  logic [7:0] dist_in = 8'd0;
  logic [7:0] thresh_near = 8'd0;
  logic [7:0] thresh_far = 8'd255;
  logic [7:0] avg_out;
  logic       avg_valid;
  logic       near;
  logic       primed;

  int errors = 0;
  int checks = 0;

  int stim_q[$];
  int m_win[$];
  int m_cnt = 0;
  int m_near = 0;
  int cur_avg = 0;
  int cur_near = 0;

  dist_filter #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .dist_valid (dist_valid),
    .dist_in    (dist_in),
    .thresh_near(thresh_near),
    .thresh_far (thresh_far),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .near       (near),
    .primed     (primed)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit rejected(input int v);
`ifdef DIST_FILTER_REJECT_EN
    return (v == 0) || (v == 255);
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    m_win.delete();
    m_cnt    = 0;
    m_near   = 0;
    cur_avg  = 0;
    cur_near = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    dist_valid = 1'b0;
    step();
    rst = 1'b0;
    m_reset();
  endtask

  // Plays stim_q (-1 = idle cycle) and checks the outputs after every edge.
  task automatic run_stream();
    int n;
    int s;
    int a;
    bit ev[512];
    int ea[512];
    int en[512];
    n = stim_q.size();
    for (int k = 0; k < 512; k++) begin
      ev[k] = 1'b0;
      ea[k] = 0;
      en[k] = 0;
    end
    for (int j = 0; j <= n; j++) begin
      if (j < n && stim_q[j] >= 0) begin
        dist_valid = 1'b1;
        dist_in    = 8'(stim_q[j]);
        if (!rejected(stim_q[j])) begin
          m_win.push_back(stim_q[j]);
          if (m_win.size() > DEPTH)
            void'(m_win.pop_front());
          m_cnt++;
          if (m_cnt >= DEPTH) begin
            s = 0;
            foreach (m_win[k]) s += m_win[k];
            a = s / DEPTH;
            if (a < int'(thresh_near))
              m_near = 1;
            else if (a > int'(thresh_far))
              m_near = 0;
            ev[j+1] = 1'b1;
            ea[j+1] = a;
            en[j+1] = m_near;
          end
        end
      end else begin
        dist_valid = 1'b0;
        dist_in    = 8'($urandom_range(0, 255));
      end
      step();
      if (ev[j]) begin
        cur_avg  = ea[j];
        cur_near = en[j];
      end
      checks++;
      if (avg_valid !== ev[j]) begin
        errors++;
        $display("FAIL avg_valid cyc%0d got=%b exp=%b", j, avg_valid, ev[j]);
      end
      checks++;
      if (avg_out !== 8'(cur_avg)) begin
        errors++;
        $display("FAIL avg_out cyc%0d got=%0d exp=%0d", j, avg_out, cur_avg);
      end
      checks++;
      if (near !== 1'(cur_near)) begin
        errors++;
        $display("FAIL near cyc%0d got=%b exp=%0d", j, near, cur_near);
      end
      checks++;
      if (primed !== (m_cnt >= DEPTH)) begin
        errors++;
        $display("FAIL primed cyc%0d got=%b exp=%0d", j, primed, m_cnt >= DEPTH);
      end
    end
    dist_valid = 1'b0;
    stim_q.delete();
  endtask

  task automatic test_reset();
    // Sample presented together with reset must be discarded.
    rst = 1'b1;
    dist_valid = 1'b1;
    dist_in = 8'd77;
    step();
    step();
    rst = 1'b0;
    dist_valid = 1'b0;
    m_reset();
    checks++;
    if ({avg_out, avg_valid, near, primed} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {avg_out, avg_valid, near, primed});
    end
    stim_q = {-1, -1, -1};
    run_stream();
  endtask

  task automatic test_fill();
    apply_reset();
    thresh_near = 8'd0;
    thresh_far  = 8'd255;
    stim_q = {10, -1, 20, 30, -1, -1, 40, -1, -1};
    run_stream();
    checks++;
    if (avg_out !== 8'd25) begin
      errors++;
      $display("FAIL fill_avg got=%0d exp=25", avg_out);
    end
  endtask

  task automatic test_back_to_back();
    stim_q = {40, 40, 40, 40, -1, 8, 8, 8, 8, 8, 8, 8, 8};
    run_stream();
    checks++;
    if (avg_out !== 8'd8) begin
      errors++;
      $display("FAIL wrap_avg got=%0d exp=8", avg_out);
    end
  endtask

  task automatic test_hysteresis();
    int want[4] = '{0, 1, 1, 0};
    int vals[4] = '{25, 15, 25, 35};
    apply_reset();
    thresh_near = 8'd20;
    thresh_far  = 8'd30;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < DEPTH; k++) stim_q.push_back(vals[g]);
      stim_q.push_back(-1);
      run_stream();
      checks++;
      if (near !== 1'(want[g]) || avg_out !== 8'(vals[g])) begin
        errors++;
        $display("FAIL hyst_group%0d got near=%b avg=%0d exp near=%0d avg=%0d",
                 g, near, avg_out, want[g], vals[g]);
      end
    end
  endtask

  task automatic test_set_priority();
    apply_reset();
    thresh_near = 8'd40;
    thresh_far  = 8'd30;
    stim_q = {35, 35, 35, 35, -1};
    run_stream();
    checks++;
    if (near !== 1'b1) begin
      errors++;
      $display("FAIL set_priority got=%b exp=1", near);
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    thresh_near = 8'd100;
    thresh_far  = 8'd150;
    stim_q = {60, 60, 60, 60, -1};
    run_stream();
    dist_valid = 1'b1;
    dist_in = 8'd200;
    step();
    dist_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_reset();
    checks++;
    if ({avg_out, avg_valid, near, primed} !== 11'd0) begin
      errors++;
      $display("FAIL midflight_reset got=%h exp=0", {avg_out, avg_valid, near, primed});
    end
    step();
    checks++;
    if (avg_valid !== 1'b0 || avg_out !== 8'd0) begin
      errors++;
      $display("FAIL midflight_strobe got vld=%b avg=%0d exp vld=0 avg=0", avg_valid, avg_out);
    end
  endtask

  task automatic test_reject();
    int exp_final;
    apply_reset();
    thresh_near = 8'd0;
    thresh_far  = 8'd255;
    stim_q = {50, 50, 50, 50, -1, 0, -1, 255, -1, -1};
    run_stream();
`ifdef DIST_FILTER_REJECT_EN
    exp_final = 50;
`else
    exp_final = 88;
`endif
    checks++;
    if (avg_out !== 8'(exp_final)) begin
      errors++;
      $display("FAIL reject_avg got=%0d exp=%0d", avg_out, exp_final);
    end
  endtask

  task automatic test_random();
    apply_reset();
    thresh_near = 8'($urandom_range(0, 255));
    thresh_far  = 8'($urandom_range(0, 255));
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: stim_q.push_back(-1);
        3:       stim_q.push_back(($urandom_range(0, 1) != 0) ? 255 : 0);
        default: stim_q.push_back(int'($urandom_range(0, 255)));
      endcase
    end
    run_stream();
    thresh_near = 8'd128;
    thresh_far  = 8'd128;
    for (int k = 0; k < 60; k++) stim_q.push_back(int'($urandom_range(0, 255)));
    run_stream();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_hysteresis();
    test_set_priority();
    test_reset_midflight();
    test_reject();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
